// File: rtl/sha256_pkg.sv
//==========================================================================
// Module   : sha256_pkg
// Purpose  : SHA-256 constants, engine state type and round helper functions
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } engineState_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Rotations are written as fixed concatenations so they map to pure wiring.
   function automatic logic [31:0] bigSigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bigSigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] smallSigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] smallSigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
//==========================================================================
// Module   : sha256_round
// Purpose  : One combinational SHA-256 round, a..h packed with a in [255:224]
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] varsIn,
   input  logic [31:0]  kIn,
   input  logic [31:0]  wIn,
   output logic [255:0] varsOut
);

   logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
   logic [31:0] w_t1, w_t2;

   assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = varsIn;

   assign w_t1 = w_h + bigSigma1(w_e) + ch(w_e, w_f, w_g) + kIn + wIn;
   assign w_t2 = bigSigma0(w_a) + maj(w_a, w_b, w_c);

   assign varsOut = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

`default_nettype wire

// File: rtl/sha256_round_engine.sv
//==========================================================================
// Module   : sha256_round_engine
// Purpose  : One 512-bit SHA-256 compression per start, ROUNDS_PER_CYCLE
//            rounds per enabled clock. Optional: SHA_DOUBLE_HASH_EN.
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic         enable,
   input  logic [511:0] block_in,
   input  logic [255:0] chain_in,
   input  logic         use_chain,
`ifdef SHA_DOUBLE_HASH_EN
   input  logic         double_hash,
`endif
   output logic         busy,
   output logic         done,
   output logic [255:0] digest_out
);

   localparam int         NUM_ITER  = 64 / ROUNDS_PER_CYCLE;
   localparam logic [5:0] LAST_ITER = 6'(NUM_ITER - 1);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
         ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_badRounds
      $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   engineState_t r_state;
   logic [5:0]   r_counter;
   logic [255:0] r_vars;
   logic [255:0] r_initHash;
   logic [511:0] r_window;
   logic [255:0] r_digest;
   logic         r_busy;
   logic         r_done;
`ifdef SHA_DOUBLE_HASH_EN
   logic         r_doubleHash;
   logic         r_secondPass;
`endif

   logic [255:0] w_initHash;
   logic [255:0] w_sum;
   logic [255:0] w_varsNext;
   logic [511:0] w_windowNext;

   assign w_initHash = use_chain ? chain_in : IV;

   // r_window holds W[t..t+15] with W[t] in the top word; each round consumes
   // the top word and appends W[t+16].
   for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
      logic [255:0] w_varsIn;
      logic [255:0] w_varsOut;
      logic [511:0] w_winIn;
      logic [511:0] w_winOut;
      logic [5:0]   w_t;
      logic [31:0]  w_wNew;

      if (i == 0) begin : g_head
         assign w_varsIn = r_vars;
         assign w_winIn  = r_window;
      end else begin : g_link
         assign w_varsIn = g_round[i-1].w_varsOut;
         assign w_winIn  = g_round[i-1].w_winOut;
      end

      assign w_t      = 6'(r_counter * 6'(ROUNDS_PER_CYCLE)) + 6'(i);
      assign w_wNew   = smallSigma1(w_winIn[63:32]) + w_winIn[223:192]
                      + smallSigma0(w_winIn[479:448]) + w_winIn[511:480];
      assign w_winOut = {w_winIn[479:0], w_wNew};

      sha256_round u_round (
         .varsIn  (w_varsIn),
         .kIn     (K[w_t]),
         .wIn     (w_winIn[511:480]),
         .varsOut (w_varsOut)
      );
   end

   assign w_varsNext   = g_round[ROUNDS_PER_CYCLE-1].w_varsOut;
   assign w_windowNext = g_round[ROUNDS_PER_CYCLE-1].w_winOut;

   for (genvar j = 0; j < 8; j++) begin : g_sum
      assign w_sum[32*j +: 32] = r_initHash[32*j +: 32] + r_vars[32*j +: 32];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_counter    <= '0;
         r_vars       <= '0;
         r_initHash   <= '0;
         r_window     <= '0;
         r_digest     <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef SHA_DOUBLE_HASH_EN
         r_doubleHash <= 1'b0;
         r_secondPass <= 1'b0;
`endif
      end else if (enable) begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_vars       <= w_initHash;
                  r_initHash   <= w_initHash;
                  r_window     <= block_in;
                  r_counter    <= '0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ROUND;
`ifdef SHA_DOUBLE_HASH_EN
                  r_doubleHash <= double_hash;
                  r_secondPass <= 1'b0;
`endif
               end
            end
            ROUND: begin
               r_vars    <= w_varsNext;
               r_window  <= w_windowNext;
               r_counter <= r_counter + 6'd1;
               if (r_counter == LAST_ITER) begin
                  r_state <= FINAL;
               end
            end
            FINAL: begin
`ifdef SHA_DOUBLE_HASH_EN
               // Second pass hashes the 256-bit first digest as a padded block.
               if (r_doubleHash && !r_secondPass) begin
                  r_vars       <= IV;
                  r_initHash   <= IV;
                  r_window     <= {w_sum, 32'h8000_0000, 192'd0, 32'h0000_0100};
                  r_counter    <= '0;
                  r_secondPass <= 1'b1;
                  r_state      <= ROUND;
               end else
`endif
               begin
                  r_digest <= w_sum;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign digest_out = r_digest;

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
//==========================================================================
// Module   : tb_sha256_round_engine
// Purpose  : Bench for sha256_round_engine at 1 and 8 rounds per cycle
// Revision : 1.0 - initial release
//==========================================================================
`default_nettype none

module tb_sha256_round_engine;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IVT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam int NITER [2] = '{64, 8};

   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'd0, 32'h00000018};
   localparam logic [511:0] BLK_LONG1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_LONG2 = {480'd0, 32'h000001c0};
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_LONG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DIG_ABC2  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

   logic         clk = 1'b0;
   logic         n_rst, start, enable, use_chain, double_hash;
   logic [511:0] block_in;
   logic [255:0] chain_in;
   logic         busy [2];
   logic         done [2];
   logic [255:0] digest [2];

   int vectors = 0;
   int miscompares = 0;

   logic         mBusy [2];
   logic         mDone [2];
   logic [255:0] mDigest [2];
   logic [255:0] mPending [2];
   int           mLeft [2];

   always #5 clk = ~clk;

   sha256_round_engine #(.ROUNDS_PER_CYCLE(1)) dutA (
      .clk(clk), .n_rst(n_rst), .start(start), .enable(enable),
      .block_in(block_in), .chain_in(chain_in), .use_chain(use_chain),
`ifdef SHA_DOUBLE_HASH_EN
      .double_hash(double_hash),
`endif
      .busy(busy[0]), .done(done[0]), .digest_out(digest[0])
   );

   sha256_round_engine #(.ROUNDS_PER_CYCLE(8)) dutB (
      .clk(clk), .n_rst(n_rst), .start(start), .enable(enable),
      .block_in(block_in), .chain_in(chain_in), .use_chain(use_chain),
`ifdef SHA_DOUBLE_HASH_EN
      .double_hash(double_hash),
`endif
      .busy(busy[1]), .done(done[1]), .digest_out(digest[1])
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 compression over a fully expanded 64-word schedule.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  h [8];
      logic [31:0]  v [8];
      logic [31:0]  s0, s1, t1, t2;
      logic [255:0] res;
      for (int j = 0; j < 8; j++) h[j] = hin[255-32*j -: 32];
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      v = h;
      for (int t = 0; t < 64; t++) begin
         s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
         t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
         t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) res[255-32*j -: 32] = h[j] + v[j];
      return res;
   endfunction

   function automatic logic [511:0] padDigest(input logic [255:0] d);
      return {d, 32'h80000000, 192'd0, 32'h00000100};
   endfunction

   function automatic logic [511:0] randBlock();
      logic [511:0] b;
      for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
      return b;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   // Transaction-level reference: a start accepted while idle fixes the result
   // and how many enabled edges remain until done.
   always @(posedge clk) begin
      logic [255:0] first, second;
      first  = compress(use_chain ? chain_in : IVT, block_in);
      second = compress(IVT, padDigest(first));
      for (int d = 0; d < 2; d++) begin
         if (!n_rst) begin
            mBusy[d] = 1'b0; mDone[d] = 1'b0; mDigest[d] = '0; mLeft[d] = 0;
         end else if (enable) begin
            if (!mBusy[d] && start) begin
               mBusy[d] = 1'b1;
               mDone[d] = 1'b0;
               mPending[d] = double_hash ? second : first;
               mLeft[d] = double_hash ? 2 * NITER[d] + 2 : NITER[d] + 1;
            end else if (mBusy[d]) begin
               mLeft[d]--;
               if (mLeft[d] == 0) begin
                  mBusy[d] = 1'b0;
                  mDone[d] = 1'b1;
                  mDigest[d] = mPending[d];
               end
            end
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("cycle busy dut%0d", d), 256'(busy[d]), 256'(mBusy[d]));
         check($sformatf("cycle done dut%0d", d), 256'(done[d]), 256'(mDone[d]));
         check($sformatf("cycle digest dut%0d", d), digest[d], mDigest[d]);
      end
   end

   // Called at a falling edge; cycle index below equals the rising edge just passed.
   task automatic runJob(input string name, input logic [511:0] blk, input logic [255:0] chn,
                         input logic uc, input logic dbl, input bit chkDigest,
                         input logic [255:0] expDigest, input int freezeAt,
                         input int extraStartAt, output logic [255:0] res);
      int lat [2];
      int cyc;
      int expLat;
      block_in = blk; chain_in = chn; use_chain = uc; double_hash = dbl;
      start = 1'b1; enable = 1'b1;
      lat = '{0, 0};
      cyc = -1;
      while ((lat[0] == 0 || lat[1] == 0) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start  = (cyc == extraStartAt);
         enable = !(freezeAt >= 0 && cyc >= freezeAt && cyc < freezeAt + 10);
         block_in = randBlock();
         chain_in = randBlock()[255:0];
         use_chain = 1'($urandom);
         for (int d = 0; d < 2; d++)
            if (done[d] && lat[d] == 0) lat[d] = cyc;
      end
      for (int d = 0; d < 2; d++) begin
         expLat = (dbl ? 2 * NITER[d] + 2 : NITER[d] + 1) + (freezeAt >= 0 ? 10 : 0);
         check($sformatf("%s latency dut%0d", name, d), 256'(lat[d]), 256'(expLat));
         if (chkDigest) check($sformatf("%s digest dut%0d", name, d), digest[d], expDigest);
      end
      res = digest[0];
   endtask

   initial begin
      logic [255:0] mid, dummy;
      n_rst = 1'b1; start = 1'b0; enable = 1'b1; use_chain = 1'b0; double_hash = 1'b0;
      block_in = '0; chain_in = '0;
      for (int d = 0; d < 2; d++) begin
         mBusy[d] = 1'b0; mDone[d] = 1'b0; mDigest[d] = '0; mPending[d] = '0; mLeft[d] = 0;
      end
      #1 n_rst = 1'b0;

      check("model empty", compress(IVT, BLK_EMPTY), DIG_EMPTY);
      check("model abc", compress(IVT, BLK_ABC), DIG_ABC);
      check("model two-block", compress(compress(IVT, BLK_LONG1), BLK_LONG2), DIG_LONG);
      check("model double abc", compress(IVT, padDigest(compress(IVT, BLK_ABC))), DIG_ABC2);

      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset busy dut%0d", d), 256'(busy[d]), 256'(0));
         check($sformatf("reset done dut%0d", d), 256'(done[d]), 256'(0));
         check($sformatf("reset digest dut%0d", d), digest[d], '0);
      end
      n_rst = 1'b1;
      @(negedge clk);

      runJob("empty", BLK_EMPTY, randBlock()[255:0], 1'b0, 1'b0, 1'b1, DIG_EMPTY, -1, -1, dummy);
      runJob("abc", BLK_ABC, randBlock()[255:0], 1'b0, 1'b0, 1'b1, DIG_ABC, -1, -1, dummy);
      runJob("long blk1", BLK_LONG1, '0, 1'b0, 1'b0, 1'b0, '0, -1, -1, mid);
      runJob("long blk2", BLK_LONG2, mid, 1'b1, 1'b0, 1'b1, DIG_LONG, -1, -1, dummy);
      runJob("abc freeze", BLK_ABC, '0, 1'b0, 1'b0, 1'b1, DIG_ABC, 4, 16, dummy);

      // Reset in the middle of a job, then a clean rerun.
      block_in = BLK_ABC; use_chain = 1'b0; double_hash = 1'b0; start = 1'b1; enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      n_rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("midreset busy dut%0d", d), 256'(busy[d]), 256'(0));
         check($sformatf("midreset done dut%0d", d), 256'(done[d]), 256'(0));
         check($sformatf("midreset digest dut%0d", d), digest[d], '0);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      runJob("abc after reset", BLK_ABC, '0, 1'b0, 1'b0, 1'b1, DIG_ABC, -1, -1, dummy);

`ifdef SHA_DOUBLE_HASH_EN
      runJob("abc double", BLK_ABC, '0, 1'b0, 1'b1, 1'b1, DIG_ABC2, -1, -1, dummy);
`endif

      // Random traffic, random enable gaps, occasional reset.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start     = ($urandom_range(0, 3) == 0);
         enable    = ($urandom_range(0, 7) != 0);
         block_in  = randBlock();
         chain_in  = randBlock()[255:0];
         use_chain = 1'($urandom);
`ifdef SHA_DOUBLE_HASH_EN
         double_hash = 1'($urandom);
`else
         double_hash = 1'b0;
`endif
         n_rst = ($urandom_range(0, 599) != 0);
      end
      @(negedge clk);
      n_rst = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
